peak_scheduler: RTL

Time-multiplexes one shared peak-finder core across NUM_PAIRS microphone-pair correlation buffers. Latches per-pair "correlation ready" pulses and grants the core round-robin. For each grant it drives the buffer-select mux, issues a one-cycle start, waits for the core's done pulse and stores the returned lag index. When every pair of the current frame has a lag, it publishes the full lag vector to the localisation stage with a one-cycle valid.

---
 rtl/peak_sched_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 28 ++
 rtl/peak_scheduler.sv | 123 ++++++++++++
 3 files changed

// File: rtl/peak_sched_pkg.sv
// Shared constants, state type and lag-width helper for the peak-finder scheduling slice.
package peak_sched_pkg;

  localparam int unsigned NUM_PAIRS_DEF = 6;
  localparam int unsigned MAX_LAGS_DEF  = 17;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_CHECK = 2'd3
  } state_e;

  // Lag index spans -MAX_LAGS..+MAX_LAGS, so 2*MAX_LAGS+1 distinct values.
  function automatic int unsigned lag_width(input int unsigned max_lags);
    return $clog2(2 * max_lags + 1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit strictly after the pointer, wrapping.
module rr_arbiter #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  logic [IDX_W-1:0] w_pos;

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    w_pos   = '0;
    // k=WIDTH lands back on the pointer itself, so it is checked last.
    for (int unsigned k = 1; k <= WIDTH; k++) begin
      w_pos = IDX_W'((32'(i_ptr) + k) % WIDTH);
      if (!o_valid && i_req[w_pos]) begin
        o_idx   = w_pos;
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/peak_scheduler.sv
// Shares one peak-finder core across NUM_PAIRS correlation buffers, collects one lag per pair
// and publishes the complete lag vector once every pair of the frame has reported.
module peak_scheduler
  import peak_sched_pkg::*;
#(
  parameter int unsigned NUM_PAIRS = NUM_PAIRS_DEF,
  parameter int unsigned MAX_LAGS  = MAX_LAGS_DEF,
  parameter int unsigned LAG_W     = lag_width(MAX_LAGS),
  parameter int unsigned TIMEOUT   = 2 * MAX_LAGS + 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PAIRS-1:0]          corrValid,
  output logic                          peakEnable,
  output logic [$clog2(NUM_PAIRS)-1:0]  pairSel,
  input  logic                          peakDone,
  input  logic [LAG_W-1:0]              peakLag,
  output logic [NUM_PAIRS*LAG_W-1:0]    lagsOut,
  output logic                          lagsValid,
  output logic [NUM_PAIRS-1:0]          errMask,
  output logic [NUM_PAIRS-1:0]          overrun
);

  localparam int unsigned SEL_W = $clog2(NUM_PAIRS);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  state_e                       r_state;
  logic [SEL_W-1:0]             r_grant;
  logic [SEL_W-1:0]             r_lastGrant;
  logic [TMR_W-1:0]             r_timer;
  logic [NUM_PAIRS-1:0]         r_pending;
  logic [NUM_PAIRS-1:0]         r_doneMask;
  logic [NUM_PAIRS-1:0]         r_err;
  logic [NUM_PAIRS*LAG_W-1:0]   r_lagVec;
  logic [NUM_PAIRS*LAG_W-1:0]   r_lagsOut;
  logic [NUM_PAIRS-1:0]         r_errMask;
  logic                         r_lagsValid;
  logic [NUM_PAIRS-1:0]         r_overrun;

  logic [SEL_W-1:0]             w_arbIdx;
  logic                         w_arbValid;
  logic                         w_finish;
  logic [NUM_PAIRS-1:0]         w_clr;

  rr_arbiter #(
    .WIDTH (NUM_PAIRS),
    .IDX_W (SEL_W)
  ) u_arb (
    .i_req   (r_pending),
    .i_ptr   (r_lastGrant),
    .o_idx   (w_arbIdx),
    .o_valid (w_arbValid)
  );

  always_comb begin
    w_clr    = '0;
    w_finish = (r_state == ST_WAIT) && (peakDone || (r_timer == TMR_W'(TIMEOUT - 1)));
    if (w_finish) w_clr[r_grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_grant     <= '0;
      r_lastGrant <= SEL_W'(NUM_PAIRS - 1);
      r_timer     <= '0;
      r_pending   <= '0;
      r_doneMask  <= '0;
      r_err       <= '0;
      r_lagVec    <= '0;
      r_lagsOut   <= '0;
      r_errMask   <= '0;
      r_lagsValid <= 1'b0;
      r_overrun   <= '0;
    end else begin
      // A new corrValid in the same cycle as the clear keeps the pair pending.
      r_pending   <= (r_pending & ~w_clr) | corrValid;
      r_overrun   <= r_overrun | (corrValid & r_pending & ~w_clr);
      r_lagsValid <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_arbValid) begin
            r_grant <= w_arbIdx;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          r_timer <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (w_finish) begin
            r_lagVec[r_grant*LAG_W +: LAG_W] <= peakDone ? peakLag : LAG_W'(MAX_LAGS);
            r_err[r_grant]      <= ~peakDone;
            r_doneMask[r_grant] <= 1'b1;
            r_lastGrant         <= r_grant;
            r_state             <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (&r_doneMask) begin
            r_lagsOut   <= r_lagVec;
            r_errMask   <= r_err;
            r_lagsValid <= 1'b1;
            r_doneMask  <= '0;
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign peakEnable = (r_state == ST_START);
  assign pairSel    = r_grant;
  assign lagsOut    = r_lagsOut;
  assign lagsValid  = r_lagsValid;
  assign errMask    = r_errMask;
  assign overrun    = r_overrun;

endmodule
